// File: rtl/seg_msg_scheduler.sv
// seg_msg_scheduler: arbitrates alert/status/default messages onto a scanned 4-digit 7-segment display
module seg_msg_scheduler #(
    parameter int HOLD_CYCLES = 1024
) (
    input  logic        segclk,
    input  logic        clr,
    input  logic        req0,
    input  logic [19:0] msg0,
    input  logic        req1,
    input  logic [19:0] msg1,
    input  logic [19:0] default_msg,
    input  logic        blank,
    output logic        grant0,
    output logic        grant1,
    output logic        busy,
    output logic [6:0]  seg,
    output logic [3:0]  an
);
    localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHOW0, SHOW1} state_t;

    state_t        state, state_nx;
    logic          pend0, pend1, last;
    logic [19:0]   buf0, buf1, disp;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          may_enter, enter0, enter1;
    logic [4:0]    ch;
    logic [6:0]    dec;

    // state register
    always_ff @(posedge segclk or posedge clr)
        if (clr) state <= IDLE;
        else     state <= state_nx;

    // next state: IDLE favours alert; at hold expiry both pending alternate away from the last shown
    always_comb begin
        state_nx = state;
        if (state == IDLE)
            state_nx = pend0 ? SHOW0 : pend1 ? SHOW1 : IDLE;
        else if (cnt == '0)
            state_nx = (pend0 && pend1) ? (last ? SHOW0 : SHOW1) :
                       pend0 ? SHOW0 : pend1 ? SHOW1 : IDLE;
    end

    // a message is loaded whenever a SHOW state is chosen from IDLE or at hold expiry
    always_comb begin
        may_enter = (state == IDLE) || (cnt == '0);
        enter0    = may_enter && (state_nx == SHOW0);
        enter1    = may_enter && (state_nx == SHOW1);
    end

    // grant pulses and busy are registered alongside the state change
    always_ff @(posedge segclk or posedge clr)
        if (clr) begin
            grant0 <= 1'b0;
            grant1 <= 1'b0;
            busy   <= 1'b0;
        end else begin
            grant0 <= enter0;
            grant1 <= enter1;
            busy   <= state_nx != IDLE;
        end

    // hold counter, last-shown requester and the display register
    always_ff @(posedge segclk or posedge clr)
        if (clr) begin
            cnt  <= '0;
            last <= 1'b1;
            disp <= '0;
        end else if (enter0 || enter1) begin
            cnt  <= CNT_LOAD;
            last <= enter1;
            disp <= enter0 ? buf0 : buf1;
        end else if (state == IDLE) begin
            disp <= default_msg;
        end else begin
            cnt  <= cnt - CW'(1);
        end

    // request capture; a new request in the grant cycle keeps the requester pending
    always_ff @(posedge segclk or posedge clr)
        if (clr) begin
            pend0 <= 1'b0;
            pend1 <= 1'b0;
            buf0  <= '0;
            buf1  <= '0;
        end else begin
            pend0 <= req0 | (pend0 & ~enter0);
            pend1 <= req1 | (pend1 & ~enter1);
            if (req0) buf0 <= msg0;
            if (req1) buf1 <= msg1;
        end

    // pick the character for the digit currently being scanned
    always_comb
        ch = idx == 2'd0 ? disp[19:15] :
             idx == 2'd1 ? disp[14:10] :
             idx == 2'd2 ? disp[9:5]   : disp[4:0];

    // character code to active-low segments {g,f,e,d,c,b,a}
    always_comb begin
        case (ch)
            5'd0:    dec = 7'b1000000;
            5'd1:    dec = 7'b1111001;
            5'd2:    dec = 7'b0100100;
            5'd3:    dec = 7'b0110000;
            5'd4:    dec = 7'b0011001;
            5'd5:    dec = 7'b0010010;
            5'd6:    dec = 7'b0000010;
            5'd7:    dec = 7'b1111000;
            5'd8:    dec = 7'b0000000;
            5'd9:    dec = 7'b0010000;
            5'd10:   dec = 7'b1001000;
            5'd11:   dec = 7'b0000110;
            5'd12:   dec = 7'b1001100;
            5'd13:   dec = 7'b0001100;
            5'd14:   dec = 7'b1000111;
            5'd15:   dec = 7'b0001000;
            5'd16:   dec = 7'b0100001;
            5'd17:   dec = 7'b0010001;
            default: dec = 7'b1111111;
        endcase
    end

    // scan one digit per cycle; seg and an are registered together so they never disagree
    always_ff @(posedge segclk or posedge clr)
        if (clr) begin
            idx <= 2'd0;
            seg <= 7'h7F;
            an  <= 4'hF;
        end else begin
            idx <= idx + 2'd1;
            seg <= blank ? 7'h7F : dec;
            an  <= blank ? 4'hF : ~(4'b1000 >> idx);
        end
endmodule

// File: tb/tb_seg_msg_scheduler.sv
// tb_seg_msg_scheduler: directed plus random stimulus checked against a behavioural display model
module tb_seg_msg_scheduler;
    localparam int HOLD = 8;

    logic        segclk = 1'b0;
    logic        clr = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, blank = 1'b0;
    logic [19:0] msg0 = '0, msg1 = '0, default_msg = '0;
    logic        grant0, grant1, busy;
    logic [6:0]  seg;
    logic [3:0]  an;

    seg_msg_scheduler #(.HOLD_CYCLES(HOLD)) dut (
        .segclk(segclk), .clr(clr),
        .req0(req0), .msg0(msg0), .req1(req1), .msg1(msg1),
        .default_msg(default_msg), .blank(blank),
        .grant0(grant0), .grant1(grant1), .busy(busy),
        .seg(seg), .an(an)
    );

    always #5 segclk = ~segclk;

    localparam logic [6:0] SEGTAB [0:17] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
        7'b1001000, 7'b0000110, 7'b1001100, 7'b0001100, 7'b1000111,
        7'b0001000, 7'b0100001, 7'b0010001};

    int errors = 0;
    int checks = 0;

    // model: who is on display (-1 = default), cycles of hold left, pending requests
    int          showing, remaining, last_k, scan;
    logic        pend [2];
    logic [19:0] bufm [2];
    logic [19:0] disp;
    bit          disp_known, seg_known;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_g0, e_g1, e_busy;

    function automatic logic [19:0] m4(int a, int b, int c, int d);
        return {a[4:0], b[4:0], c[4:0], d[4:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        showing = -1; remaining = 0; last_k = 1; scan = 0;
        pend[0] = 0; pend[1] = 0; bufm[0] = '0; bufm[1] = '0;
        disp = '0; disp_known = 0; seg_known = 1;
        e_seg = 7'h7F; e_an = 4'hF; e_g0 = 0; e_g1 = 0; e_busy = 0;
    endtask

    task automatic model_edge();
        int code, pick;
        if (blank) begin
            e_seg = 7'h7F; e_an = 4'hF; seg_known = 1;
        end else begin
            code = int'((disp >> (5 * (3 - scan))) & 20'h1F);
            e_seg = code < 18 ? SEGTAB[code] : 7'h7F;
            e_an = 4'hF;
            e_an[3 - scan] = 1'b0;
            seg_known = disp_known;
        end
        scan = (scan + 1) % 4;
        pick = -1;
        if (showing < 0 || remaining == 1) begin
            if (pend[0] && pend[1]) pick = showing < 0 ? 0 : 1 - last_k;
            else if (pend[0]) pick = 0;
            else if (pend[1]) pick = 1;
        end
        if (pick >= 0) begin
            disp = bufm[pick]; disp_known = 1;
            showing = pick; remaining = HOLD; last_k = pick; pend[pick] = 0;
        end else if (showing < 0) begin
            disp = default_msg; disp_known = 1;
        end else if (remaining == 1) begin
            showing = -1;
        end else begin
            remaining--;
        end
        e_g0 = pick == 0;
        e_g1 = pick == 1;
        e_busy = showing >= 0;
        if (req0) begin pend[0] = 1; bufm[0] = msg0; end
        if (req1) begin pend[1] = 1; bufm[1] = msg1; end
    endtask

    task automatic step();
        @(posedge segclk);
        if (!clr) model_edge();
        @(negedge segclk);
        chk("grant0", grant0, e_g0);
        chk("grant1", grant1, e_g1);
        chk("busy", busy, e_busy);
        chk("an", an, e_an);
        if (seg_known) chk("seg", seg, e_seg);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_seg"}, seg, 7'h7F);
        chk({tag, "_an"}, an, 4'hF);
        chk({tag, "_grant0"}, grant0, 1'b0);
        chk({tag, "_grant1"}, grant1, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        model_reset();
        default_msg = m4(10, 11, 12, 13);
        repeat (2) @(negedge segclk);
        reset_checks("reset");
        clr = 1'b0;
        run(8);

        msg1 = m4(13, 14, 15, 17); req1 = 1; step(); req1 = 0;
        run(12);

        msg0 = m4(1, 2, 3, 4); msg1 = m4(5, 6, 7, 8); req0 = 1; req1 = 1; step();
        req0 = 0; req1 = 0;
        run(20);

        msg1 = m4(9, 8, 7, 6); req1 = 1; step(); req1 = 0;
        run(3);
        msg0 = m4(15, 14, 11, 12); req0 = 1; step(); req0 = 0;
        run(8);
        req0 = 1; req1 = 1; step(); req0 = 0; req1 = 0;
        run(28);

        req1 = 1; step(); req1 = 0;
        run(2);
        msg0 = m4(1, 1, 1, 1); req0 = 1; step(); req0 = 0;
        run(1);
        msg0 = m4(2, 2, 2, 2); req0 = 1; step(); req0 = 0;
        run(20);

        msg0 = m4(0, 5, 16, 17); req0 = 1; step(); req0 = 0;
        run(3);
        blank = 1; run(4);
        blank = 0; run(6);

        req0 = 1; step(); req0 = 0;
        run(2);
        req1 = 1; step(); req1 = 0;
        #2 clr = 1;
        #1 reset_checks("async_clr");
        model_reset();
        @(negedge segclk);
        @(negedge segclk);
        clr = 0;
        run(12);

        repeat (600) begin
            req0 = $urandom_range(0, 9) == 0;
            req1 = $urandom_range(0, 9) == 0;
            msg0 = 20'($urandom);
            msg1 = 20'($urandom);
            blank = $urandom_range(0, 15) == 0;
            if ($urandom_range(0, 31) == 0) default_msg = 20'($urandom);
            step();
        end
        req0 = 0; req1 = 0; blank = 0;
        run(24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg_msg_scheduler.md
Name: seg_msg_scheduler

Overview:
- Shares the 4-digit 7-segment display between two message requesters (req0 = alert, req1 = status) and a default message.
- Arbitrates between the requesters and holds each granted message for a minimum time.
- Performs the digit scan itself, with one digit per segclk cycle, left to right.
- Sits between the maze game logic and the board display pins.

Parameters:
- HOLD_CYCLES, 1024: segclk cycles a granted message stays on display. Minimum legal value is 1.

Ports:
- segclk in 1: display scan clock.
- clr in 1: reset, asynchronous, active-high.
- req0 in 1: alert request. Sampled every cycle.
- msg0 in 20: alert message, 4 x 5-bit char codes; [19:15] is the leftmost digit.
- req1 in 1: status request.
- msg1 in 20: status message, same format as msg0.
- default_msg in 20: message shown when no grant is active. Used live, not latched.
- blank in 1: forces the display dark. Arbitration continues while blank is high.
- grant0 out 1: one-cycle pulse when the alert message is loaded for display.
- grant1 out 1: one-cycle pulse when the status message is loaded for display.
- busy out 1: high while in SHOW0 or SHOW1.
- seg out 7: segments, active-low, bit order {g,f,e,d,c,b,a}.
- an out 4: anodes, active-low, an[3] is the leftmost digit.

Behaviour:
- Char decode (code: seg):
  - 0: 1000000; 1: 1111001; 2: 0100100; 3: 0110000; 4: 0011001
  - 5: 0010010; 6: 0000010; 7: 1111000; 8: 0000000; 9: 0010000
  - 10 N: 1001000; 11 E: 0000110; 12 R: 1001100; 13 P: 0001100
  - 14 L: 1000111; 15 A: 0001000; 16 d: 0100001; 17 Y: 0010001
  - 18-31: blank, 1111111.
- Reset (clr high, asynchronous): seg=1111111, an=1111, grant0=grant1=0, busy=0, state=IDLE, pend0=pend1=0, buf0=buf1=0, scan index=0, last-shown=1.
- Capture: any cycle with reqk=1 sets pendk=1 and buf_k<=msgk; the latest request overwrites.
  - If reqk=1 in the same cycle pendk is cleared by a grant, the set wins: pendk stays 1 and buf_k takes the new msg.
- FSM states: IDLE, SHOW0, SHOW1.
  - IDLE: display register follows default_msg every cycle. If pend0=1, go to SHOW0; else if pend1=1, go to SHOW1. Both pending: SHOW0.
  - Entering SHOWk:
    - display register <= buf_k
    - pendk <= 0
    - hold counter <= HOLD_CYCLES-1
    - grantk=1 for exactly the transition cycle
    - last-shown <= k
  - In SHOWk: the counter decrements each cycle. At zero the next state is chosen:
    - both pending: the requester not equal to last-shown (round-robin);
    - only one pending: that requester (re-entering the same SHOWk is allowed and pulses grantk again);
    - none pending: IDLE.
  - No preemption: a pending request waits for hold expiry. Total display time per grant is exactly HOLD_CYCLES cycles.
- busy is registered and equals (state != IDLE).
- Scan:
  - 2-bit index increments every cycle and wraps 3->0.
  - Index 0 gives an=0111 with char [19:15]; 1 gives 1011 with [14:10]; 2 gives 1101 with [9:5]; 3 gives 1110 with [4:0].
  - seg and an are registered together and are never mismatched. They are produced from the index and the display register as they stand at the clock edge.
  - A newly loaded message appears from the cycle after the grant.
- blank=1: an=1111 and seg=1111111 on the next edge. The scan index and FSM continue advancing.
- Reset mid-hold: everything returns to reset values immediately. Pending requests are lost.

Test Plan:
- Reset then release with default_msg={10,11,12,13}, HOLD_CYCLES=8 -> over 4 cycles (an,seg) = (0111,1001000), (1011,0000110), (1101,1001100), (1110,0001100), then repeats; busy=0.
- One-cycle req1 with msg1={13,14,15,17} -> grant1 pulses 1 cycle; busy=1 for exactly 8 cycles; digits read P,L,A,Y; then the default returns and busy=0.
- req0 and req1 pulsed in the same cycle from IDLE -> grant0 first; 8 cycles later grant1; then IDLE.
- req0 during SHOW1 -> no preemption; grant0 exactly at SHOW1 expiry. req0 and req1 both re-pending at the end of SHOW0 -> grant1 next (round-robin).
- req0 pulsed twice during SHOW1, first with {1,1,1,1} then {2,2,2,2} -> a single grant0; display shows 2222.
- blank=1 mid-SHOW0 -> an=1111, seg=1111111; hold still expires at cycle 8. clr asserted mid-SHOW0 -> outputs return to reset values asynchronously and pending requests are cleared.
